tilt_move_gen: RTL and testbench

Producer side of the ball's movement interface. Converts signed accelerometer tilt samples into the one-hot `movement` code and the slow `update` clock that the ball logic consumes on `posedge update`. Step rate is proportional to tilt beyond a dead zone. Each step is presented for exactly one `update` period, and steps are spaced so the ball finishes its collision scan before the next one arrives.

---
 rtl/ball_pkg.sv | 29 ++
 rtl/update_divider.sv | 40 ++++
 rtl/tilt_move_gen.sv | 169 ++++++++++++++++
 tb/tb_tilt_move_gen.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ball_pkg.sv
// rtl/ball_pkg.sv - shared movement codes and step FSM encoding
package ball_pkg;

    localparam logic [3:0] MOVE_NONE  = 4'b0000;
    localparam logic [3:0] MOVE_UP    = 4'b0001;
    localparam logic [3:0] MOVE_DOWN  = 4'b0010;
    localparam logic [3:0] MOVE_LEFT  = 4'b0100;
    localparam logic [3:0] MOVE_RIGHT = 4'b1000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_GAP   = 2'd2
    } move_state_e;

    typedef enum logic {
        AXIS_X = 1'b0,
        AXIS_Y = 1'b1
    } axis_e;

    // One-hot direction for the winning axis; a negative sample points up/left.
    function automatic logic [3:0] move_dir(input axis_e axis, input logic negative);
        if (axis == AXIS_X) begin
            return negative ? MOVE_LEFT : MOVE_RIGHT;
        end
        return negative ? MOVE_UP : MOVE_DOWN;
    endfunction

endpackage

// File: rtl/update_divider.sv
// rtl/update_divider.sv - update square wave generator with fall-tick strobe
module update_divider #(
    parameter int unsigned HALF = 5
) (
    input  logic clk,
    input  logic reset,
    output logic update,
    output logic fall_tick
);

    localparam int CNT_W = (HALF > 1) ? $clog2(HALF) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             update_q, update_d;
    logic             wrap;

    assign wrap = (cnt_q == CNT_W'(HALF - 1));

    // Count HALF clocks per half-period, toggling update on each wrap.
    always_comb begin
        cnt_d    = wrap ? '0 : cnt_q + 1'b1;
        update_d = wrap ? ~update_q : update_q;
    end

    // Divider state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q    <= '0;
            update_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            update_q <= update_d;
        end
    end

    assign update    = update_q;
    // High on the edge where update goes 1 -> 0.
    assign fall_tick = wrap & update_q;

endmodule

// File: rtl/tilt_move_gen.sv
// rtl/tilt_move_gen.sv - tilt samples to one-hot movement steps on a slow update clock
module tilt_move_gen
    import ball_pkg::*;
#(
    parameter int unsigned CLK_FREQUENCY_HZ       = 100000000,
    parameter int unsigned UPDATE_FREQUENCY_HZ    = 2000,
    parameter int unsigned SIMULATE               = 0,
    parameter int unsigned SIMULATE_FREQUENCY_CNT = 5,
    parameter int unsigned ACCEL_WIDTH            = 12,
    parameter int unsigned DEADZONE               = 64,
    parameter int unsigned ACC_WIDTH              = 16,
    parameter int unsigned STEP_THRESHOLD         = 4096,
    parameter int unsigned MIN_GAP                = 64,
    parameter int unsigned STALE_CYCLES           = 10000000
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic signed [ACCEL_WIDTH-1:0] accel_x,
    input  logic signed [ACCEL_WIDTH-1:0] accel_y,
    input  logic                          accel_valid,
    output logic                          update,
    output logic [3:0]                    movement,
    output logic                          busy
);

    localparam int unsigned HALF = (SIMULATE != 0) ? SIMULATE_FREQUENCY_CNT
                                                   : CLK_FREQUENCY_HZ / (2 * UPDATE_FREQUENCY_HZ);
    localparam int STALE_W = $clog2(STALE_CYCLES + 1);
    localparam int GAP_W   = (MIN_GAP > 0) ? $clog2(MIN_GAP + 1) : 1;

    localparam logic [ACCEL_WIDTH-1:0] DZ    = ACCEL_WIDTH'(DEADZONE);
    localparam logic [ACC_WIDTH-1:0]   THR   = ACC_WIDTH'(STEP_THRESHOLD);
    localparam logic [STALE_W-1:0]     STALE = STALE_W'(STALE_CYCLES);

    // Two's-complement magnitude kept unsigned so the most negative value maps to 2^(W-1).
    function automatic logic [ACCEL_WIDTH-1:0] abs_val(input logic [ACCEL_WIDTH-1:0] v);
        return v[ACCEL_WIDTH-1] ? (~v + 1'b1) : v;
    endfunction

    logic                          fall_tick;
    logic signed [ACCEL_WIDTH-1:0] x_q, y_q;
    logic [STALE_W-1:0]            stale_q, stale_d;
    logic                          stale;

    move_state_e                   state_q, state_d;
    axis_e                         last_axis_q, last_axis_d;
    axis_e                         dom_axis;
    logic [ACC_WIDTH-1:0]          acc_q, acc_d, acc_base, acc_add;
    logic [ACC_WIDTH:0]            acc_sum;
    logic [GAP_W-1:0]              gap_q, gap_d;
    logic [3:0]                    movement_q, movement_d;

    logic [ACCEL_WIDTH-1:0]        mag_x, mag_y, exc_x, exc_y, exc_sel;
    logic [3:0]                    dir;

    update_divider #(
        .HALF(HALF)
    ) u_div (
        .clk      (clk),
        .reset    (reset),
        .update   (update),
        .fall_tick(fall_tick)
    );

    assign stale = (stale_q >= STALE);

    // Stale counter restarts on every sample and saturates once stale.
    always_comb begin
        stale_d = stale_q;
        if (accel_valid) begin
            stale_d = '0;
        end else if (!stale) begin
            stale_d = stale_q + 1'b1;
        end
    end

    // Sample capture and stale tracking; starts stale until the first sample.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x_q     <= '0;
            y_q     <= '0;
            stale_q <= STALE;
        end else begin
            if (accel_valid) begin
                x_q <= accel_x;
                y_q <= accel_y;
            end
            stale_q <= stale_d;
        end
    end

    // Per-axis excess over the dead zone, winning axis, and saturating accumulate.
    always_comb begin
        mag_x    = stale ? '0 : abs_val(x_q);
        mag_y    = stale ? '0 : abs_val(y_q);
        exc_x    = (mag_x > DZ) ? mag_x - DZ : '0;
        exc_y    = (mag_y > DZ) ? mag_y - DZ : '0;
        dom_axis = (mag_x >= mag_y) ? AXIS_X : AXIS_Y;
        exc_sel  = (dom_axis == AXIS_X) ? exc_x : exc_y;
        dir      = move_dir(dom_axis, (dom_axis == AXIS_X) ? x_q[ACCEL_WIDTH-1] : y_q[ACCEL_WIDTH-1]);
        acc_base = stale ? '0 : acc_q;
        acc_sum  = {1'b0, acc_base} + {{(ACC_WIDTH + 1 - ACCEL_WIDTH){1'b0}}, exc_sel};
        acc_add  = acc_sum[ACC_WIDTH] ? '1 : acc_sum[ACC_WIDTH-1:0];
    end

    // Step FSM: advances only on fall ticks so movement is steady at update rising edges.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        gap_d       = gap_q;
        last_axis_d = last_axis_q;
        movement_d  = movement_q;
        if (fall_tick) begin
            case (state_q)
                ST_IDLE: begin
                    if (dom_axis != last_axis_q) begin
                        acc_d       = '0;
                        last_axis_d = dom_axis;
                    end else if (acc_add >= THR) begin
                        acc_d      = acc_add - THR;
                        movement_d = dir;
                        state_d    = ST_PULSE;
                    end else begin
                        acc_d = acc_add;
                    end
                end
                ST_PULSE: begin
                    movement_d = MOVE_NONE;
                    gap_d      = GAP_W'(MIN_GAP);
                    state_d    = ST_GAP;
                end
                ST_GAP: begin
                    gap_d = (gap_q != '0) ? gap_q - 1'b1 : '0;
                    if (gap_q <= GAP_W'(1)) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d    = ST_IDLE;
                    movement_d = MOVE_NONE;
                end
            endcase
        end
        if (stale) begin
            acc_d = '0;
        end
    end

    // FSM, accumulator, gap counter and movement registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            gap_q       <= '0;
            last_axis_q <= AXIS_X;
            movement_q  <= MOVE_NONE;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            gap_q       <= gap_d;
            last_axis_q <= last_axis_d;
            movement_q  <= movement_d;
        end
    end

    assign movement = movement_q;
    assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_tilt_move_gen.sv
// tb/tb_tilt_move_gen.sv - directed self-checking bench for tilt_move_gen
module tb_tilt_move_gen;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic signed [11:0] accel_x = '0;
    logic signed [11:0] accel_y = '0;
    logic               accel_valid = 1'b0;
    logic               update;
    logic [3:0]         movement;
    logic               busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit strobe_en = 1'b0;

    tilt_move_gen #(
        .SIMULATE              (1),
        .SIMULATE_FREQUENCY_CNT(5),
        .ACCEL_WIDTH           (12),
        .DEADZONE              (64),
        .ACC_WIDTH             (16),
        .STEP_THRESHOLD        (108),
        .MIN_GAP               (4),
        .STALE_CYCLES          (100)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .accel_x    (accel_x),
        .accel_y    (accel_y),
        .accel_valid(accel_valid),
        .update     (update),
        .movement   (movement),
        .busy       (busy)
    );

    initial forever #5 clk = ~clk;

    // One clock: outputs of edge cyc are visible on return; strobe every 20 clocks.
    task automatic step_clk();
        @(negedge clk);
        cyc++;
        accel_valid = strobe_en && (cyc % 20 == 0);
    endtask

    task automatic run_to(input int n);
        while (cyc < n) step_clk();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        accel_valid = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        cyc = 0;
        accel_valid = strobe_en;
    endtask

    task automatic test_reset();
        logic exp_u;
        strobe_en = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (update !== 1'b0 || movement !== 4'b0000 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_outputs: got update=%b movement=%b busy=%b expected 0 0000 0", update, movement, busy);
        end
        reset = 1'b1;
        cyc = 0;
        for (int c = 1; c <= 40; c++) begin
            step_clk();
            exp_u = ((c / 5) % 2) == 1;
            total++;
            if (update !== exp_u) begin
                bad++;
                $display("FAIL reset_update_c%0d: got %b expected %b", c, update, exp_u);
            end
            total++;
            if (movement !== 4'b0000) begin
                bad++;
                $display("FAIL reset_movement_c%0d: got %b expected 0000", c, movement);
            end
        end
    endtask

    task automatic test_steady_right();
        logic [3:0] exp_m;
        logic       exp_b;
        accel_x = 12'sd100;
        accel_y = 12'sd0;
        strobe_en = 1'b1;
        do_reset();
        for (int c = 1; c <= 85; c++) begin
            step_clk();
            exp_m = (c >= 30 && c < 40) ? 4'b1000 : 4'b0000;
            exp_b = (c >= 30 && c < 80);
            total++;
            if (movement !== exp_m) begin
                bad++;
                $display("FAIL right_movement_c%0d: got %b expected %b", c, movement, exp_m);
            end
            total++;
            if (busy !== exp_b) begin
                bad++;
                $display("FAIL right_busy_c%0d: got %b expected %b", c, busy, exp_b);
            end
        end
    endtask

    task automatic test_deadzone();
        logic seen;
        accel_x = 12'sd40;
        accel_y = -12'sd50;
        strobe_en = 1'b1;
        do_reset();
        seen = 1'b0;
        for (int c = 1; c <= 10000; c++) begin
            step_clk();
            if (movement !== 4'b0000) seen = 1'b1;
        end
        total++;
        if (seen !== 1'b0) begin
            bad++;
            $display("FAIL deadzone_move: got a nonzero movement expected 0000 throughout");
        end
    endtask

    task automatic test_axis_left();
        int         cl[4] = '{9, 10, 19, 20};
        logic [3:0] el[4] = '{4'b0000, 4'b0100, 4'b0100, 4'b0000};
        accel_x = -12'sd300;
        accel_y = 12'sd200;
        strobe_en = 1'b1;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            run_to(cl[i]);
            total++;
            if (movement !== el[i]) begin
                bad++;
                $display("FAIL left_c%0d: got %b expected %b", cl[i], movement, el[i]);
            end
        end
    endtask

    task automatic test_tie_spacing();
        int         cl[8] = '{9, 10, 19, 20, 69, 70, 79, 80};
        logic [3:0] el[8] = '{4'b0000, 4'b1000, 4'b1000, 4'b0000, 4'b0000, 4'b1000, 4'b1000, 4'b0000};
        accel_x = 12'sd200;
        accel_y = 12'sd200;
        strobe_en = 1'b1;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            run_to(cl[i]);
            total++;
            if (movement !== el[i]) begin
                bad++;
                $display("FAIL tie_c%0d: got %b expected %b", cl[i], movement, el[i]);
            end
        end
    endtask

    task automatic test_axis_switch();
        int         cl[5] = '{70, 79, 80, 89, 90};
        logic [3:0] el[5] = '{4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0000};
        accel_x = 12'sd200;
        accel_y = 12'sd200;
        strobe_en = 1'b1;
        do_reset();
        run_to(10);
        total++;
        if (movement !== 4'b1000) begin
            bad++;
            $display("FAIL switch_first_right: got %b expected 1000", movement);
        end
        run_to(12);
        accel_x = 12'sd0;
        accel_y = -12'sd300;
        for (int i = 0; i < 5; i++) begin
            run_to(cl[i]);
            total++;
            if (movement !== el[i]) begin
                bad++;
                $display("FAIL switch_c%0d: got %b expected %b", cl[i], movement, el[i]);
            end
        end
    endtask

    task automatic test_stale();
        int         cl[8] = '{9, 10, 19, 20, 69, 70, 79, 80};
        logic [3:0] el[8] = '{4'b0000, 4'b1000, 4'b1000, 4'b0000, 4'b0000, 4'b1000, 4'b1000, 4'b0000};
        logic       seen;
        accel_x = 12'sd300;
        accel_y = 12'sd0;
        strobe_en = 1'b1;
        do_reset();
        strobe_en = 1'b0;
        for (int i = 0; i < 8; i++) begin
            run_to(cl[i]);
            total++;
            if (movement !== el[i]) begin
                bad++;
                $display("FAIL stale_c%0d: got %b expected %b", cl[i], movement, el[i]);
            end
        end
        seen = 1'b0;
        for (int c = 81; c <= 400; c++) begin
            step_clk();
            if (movement !== 4'b0000) seen = 1'b1;
        end
        total++;
        if (seen !== 1'b0) begin
            bad++;
            $display("FAIL stale_quiet: got a nonzero movement after going stale expected 0000");
        end
    endtask

    task automatic test_reset_mid_pulse();
        accel_x = 12'sd100;
        accel_y = 12'sd0;
        strobe_en = 1'b1;
        do_reset();
        run_to(36);
        total++;
        if (movement !== 4'b1000 || update !== 1'b1) begin
            bad++;
            $display("FAIL midpulse_pre: got movement=%b update=%b expected 1000 1", movement, update);
        end
        reset = 1'b0;
        #1;
        total++;
        if (movement !== 4'b0000 || update !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL midpulse_async: got movement=%b update=%b busy=%b expected 0000 0 0", movement, update, busy);
        end
        do_reset();
        run_to(29);
        total++;
        if (movement !== 4'b0000) begin
            bad++;
            $display("FAIL midpulse_after_c29: got %b expected 0000", movement);
        end
        run_to(30);
        total++;
        if (movement !== 4'b1000) begin
            bad++;
            $display("FAIL midpulse_after_c30: got %b expected 1000", movement);
        end
    endtask

    initial begin
        test_reset();
        test_steady_right();
        test_deadzone();
        test_axis_left();
        test_tie_spacing();
        test_axis_switch();
        test_stale();
        test_reset_mid_pulse();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
